// File: rtl/noise_injector.sv
// Adds 16-bit Galois-LFSR noise to an AXI-Stream sample, with output register plus skid buffer.
// Define NOISE_SAT_EN to clamp overflowing sums and count clamps; otherwise sums wrap.
module noise_injector #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned NOISE_SHIFT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             noise_enable,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [15:0]      sat_count
);

  logic [15:0]       r_lfsr;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_skid_data;
  logic              r_skid_valid;

  logic              w_accept;
  logic              w_out_free;
  logic [15:0]       w_lfsr_next;
  logic signed [15:0] w_noise16;
  logic [WIDTH-1:0]  w_result;

  assign w_accept    = s_axis_tvalid && !r_skid_valid;
  assign w_out_free  = !r_out_valid || m_axis_tready;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_noise16   = $signed(r_lfsr) >>> NOISE_SHIFT;

`ifdef NOISE_SAT_EN
  logic signed [WIDTH:0] w_noise;
  logic [WIDTH:0]        w_sum;
  logic                  w_clamp;
  logic [15:0]           r_sat_count;

  always_comb begin
    w_noise = '0;
    if (noise_enable) w_noise = (WIDTH+1)'(w_noise16);
  end

  assign w_sum   = {s_axis_tdata[WIDTH-1], s_axis_tdata} + w_noise;
  // Overflow shows up as disagreement between the guard bit and the result sign bit.
  assign w_clamp = w_sum[WIDTH] ^ w_sum[WIDTH-1];

  always_comb begin
    w_result = w_sum[WIDTH-1:0];
    if (w_clamp) begin
      if (w_sum[WIDTH]) w_result = {1'b1, {(WIDTH-1){1'b0}}};
      else              w_result = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (w_accept && w_clamp && (r_sat_count != 16'hFFFF)) begin
      r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign sat_count = r_sat_count;
`else
  logic signed [WIDTH-1:0] w_noise;

  always_comb begin
    w_noise = '0;
    if (noise_enable) w_noise = WIDTH'(w_noise16);
  end

  assign w_result  = s_axis_tdata + w_noise;
  assign sat_count = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= LFSR_SEED;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_accept && noise_enable) r_lfsr <= w_lfsr_next;

      if (w_out_free) begin
        // A full skid implies s_axis_tready is low, so no new beat competes with it.
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data  <= w_result;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign s_axis_tready = !r_skid_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;

endmodule
